// File: rtl/rip_trap_ctrl_pkg.sv
// Shared types and constants for the RIP machine-mode trap controller.
package rip_trap_ctrl_pkg;

  localparam int XLEN    = 32;
  localparam int CAUSE_W = 4;

  localparam logic [11:0] CSR_MTVEC  = 12'h305;
  localparam logic [11:0] CSR_MEPC   = 12'h341;
  localparam logic [11:0] CSR_MCAUSE = 12'h342;

  localparam logic [CAUSE_W-1:0] CAUSE_ILLEGAL_INST = 4'd2;
  localparam logic [CAUSE_W-1:0] CAUSE_ECALL        = 4'd11;

  typedef enum logic [1:0] {
    CSR_READ = 2'b00,
    CSR_RW   = 2'b01,
    CSR_RS   = 2'b10,
    CSR_RC   = 2'b11
  } csr_op_t;

  typedef enum logic [1:0] {
    IDLE,
    SAVE,
    REDIRECT
  } trap_state_t;

  function automatic logic [XLEN-1:0] csr_apply(input csr_op_t op,
                                                input logic [XLEN-1:0] old_val,
                                                input logic [XLEN-1:0] wdata);
    case (op)
      CSR_RW:  csr_apply = wdata;
      CSR_RS:  csr_apply = old_val | wdata;
      CSR_RC:  csr_apply = old_val & ~wdata;
      default: csr_apply = old_val;
    endcase
  endfunction

endpackage

// File: rtl/rip_csr_regs.sv
// MTVEC/MEPC/MCAUSE storage with address decode and RW/RS/RC update.
// The trap-save port takes precedence over the CSR instruction port.
module rip_csr_regs
  import rip_trap_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               csr_we,
  input  logic [1:0]         csr_op,
  input  logic [11:0]        csr_addr,
  input  logic [XLEN-1:0]    csr_wdata,
  output logic [XLEN-1:0]    csr_rdata,
  output logic               csr_illegal,
  input  logic               save_we,
  input  logic [XLEN-1:0]    save_pc,
  input  logic [CAUSE_W-1:0] save_cause,
  output logic [XLEN-1:0]    mtvec,
  output logic [XLEN-1:0]    mepc
);

  localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(3));

  logic [XLEN-1:0] mcause;
  logic            sel_mtvec, sel_mepc, sel_mcause;
  logic [XLEN-1:0] old_val, new_val;
  csr_op_t         op_e;
  logic            do_write;

  assign op_e       = csr_op_t'(csr_op);
  assign sel_mtvec  = (csr_addr == CSR_MTVEC);
  assign sel_mepc   = (csr_addr == CSR_MEPC);
  assign sel_mcause = (csr_addr == CSR_MCAUSE);
  assign csr_illegal = ~(sel_mtvec | sel_mepc | sel_mcause);

  always_comb begin
    old_val = '0;
    if (sel_mtvec)  old_val = mtvec;
    if (sel_mepc)   old_val = mepc;
    if (sel_mcause) old_val = mcause;
  end

  assign csr_rdata = old_val;
  assign new_val   = csr_apply(op_e, old_val, csr_wdata);
  assign do_write  = csr_we & ~csr_illegal & (op_e != CSR_READ);

  always_ff @(posedge clk) begin
    if (rst) begin
      mtvec  <= '0;
      mepc   <= '0;
      mcause <= '0;
    end else if (save_we) begin
      mepc   <= save_pc & ALIGN_MASK;
      mcause <= {{(XLEN-CAUSE_W){1'b0}}, save_cause};
    end else if (do_write) begin
      if (sel_mtvec)  mtvec  <= new_val & ALIGN_MASK;
      if (sel_mepc)   mepc   <= new_val & ALIGN_MASK;
      if (sel_mcause) mcause <= new_val;
    end
  end

endmodule

// File: rtl/rip_trap_ctrl.sv
// Machine-mode trap controller: trap entry, MRET return and CSR port.
//   state    | meaning
//   IDLE     | accepting trap, then MRET, then CSR requests
//   SAVE     | writing MEPC/MCAUSE, sampling MTVEC as redirect target
//   REDIRECT | one-cycle redirect_valid + flush
module rip_trap_ctrl
  import rip_trap_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               trap_valid,
  input  logic [CAUSE_W-1:0] trap_cause,
  input  logic [XLEN-1:0]    trap_pc,
  output logic               trap_ready,
  input  logic               mret_valid,
  output logic               mret_ready,
  input  logic               csr_valid,
  input  logic [1:0]         csr_op,
  input  logic [11:0]        csr_addr,
  input  logic [XLEN-1:0]    csr_wdata,
  output logic               csr_ready,
  output logic [XLEN-1:0]    csr_rdata,
  output logic               csr_illegal,
  output logic               redirect_valid,
  output logic [XLEN-1:0]    redirect_pc,
  output logic               flush,
  output logic               busy
);

  trap_state_t        state;
  logic               idle;
  logic [XLEN-1:0]    pc_q;
  logic [CAUSE_W-1:0] cause_q;
  logic [XLEN-1:0]    mtvec, mepc;

  assign idle       = (state == IDLE);
  assign trap_ready = idle & trap_valid;
  assign mret_ready = idle & mret_valid & ~trap_valid;
  assign csr_ready  = idle & ~trap_valid & ~mret_valid;

  rip_csr_regs u_csr_regs (
    .clk         (clk),
    .rst         (rst),
    .csr_we      (csr_valid & csr_ready),
    .csr_op      (csr_op),
    .csr_addr    (csr_addr),
    .csr_wdata   (csr_wdata),
    .csr_rdata   (csr_rdata),
    .csr_illegal (csr_illegal),
    .save_we     (state == SAVE),
    .save_pc     (pc_q),
    .save_cause  (cause_q),
    .mtvec       (mtvec),
    .mepc        (mepc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      flush          <= 1'b0;
      busy           <= 1'b0;
      pc_q           <= '0;
      cause_q        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (trap_valid) begin
            pc_q    <= trap_pc;
            cause_q <= trap_cause;
            busy    <= 1'b1;
            state   <= SAVE;
          end else if (mret_valid) begin
            redirect_pc    <= mepc;
            redirect_valid <= 1'b1;
            flush          <= 1'b1;
            busy           <= 1'b1;
            state          <= REDIRECT;
          end
        end
        SAVE: begin
          // MTVEC cannot change here: the CSR port is closed outside IDLE.
          redirect_pc    <= mtvec;
          redirect_valid <= 1'b1;
          flush          <= 1'b1;
          state          <= REDIRECT;
        end
        REDIRECT: begin
          redirect_valid <= 1'b0;
          flush          <= 1'b0;
          busy           <= 1'b0;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rip_trap_ctrl.sv
// Self-checking bench for rip_trap_ctrl: directed plan plus random traffic
// against a timeline-based reference model.
module tb_rip_trap_ctrl;
  import rip_trap_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        trap_valid;
  logic [3:0]  trap_cause;
  logic [31:0] trap_pc;
  logic        trap_ready;
  logic        mret_valid;
  logic        mret_ready;
  logic        csr_valid;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic        csr_ready;
  logic [31:0] csr_rdata;
  logic        csr_illegal;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  rip_trap_ctrl dut (
    .clk(clk), .rst(rst),
    .trap_valid(trap_valid), .trap_cause(trap_cause), .trap_pc(trap_pc),
    .trap_ready(trap_ready),
    .mret_valid(mret_valid), .mret_ready(mret_ready),
    .csr_valid(csr_valid), .csr_op(csr_op), .csr_addr(csr_addr),
    .csr_wdata(csr_wdata), .csr_ready(csr_ready), .csr_rdata(csr_rdata),
    .csr_illegal(csr_illegal),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .flush(flush), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: CSR values plus the number of busy cycles still ahead.
  logic [31:0] m_mtvec, m_mepc, m_mcause;
  int          m_left;
  logic [31:0] m_pc, m_target;
  logic [3:0]  m_cause;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_legal(input logic [11:0] a);
    return (a == 12'h305) || (a == 12'h341) || (a == 12'h342);
  endfunction

  function automatic logic [31:0] m_read(input logic [11:0] a);
    if (a == 12'h305) return m_mtvec;
    if (a == 12'h341) return m_mepc;
    if (a == 12'h342) return m_mcause;
    return 32'h0;
  endfunction

  task automatic model_check();
    bit idle;
    idle = (m_left == 0);
    chk("trap_ready", {31'b0, trap_ready}, {31'b0, idle && trap_valid});
    chk("mret_ready", {31'b0, mret_ready}, {31'b0, idle && mret_valid && !trap_valid});
    chk("csr_ready", {31'b0, csr_ready}, {31'b0, idle && !trap_valid && !mret_valid});
    chk("csr_illegal", {31'b0, csr_illegal}, {31'b0, !m_legal(csr_addr)});
    chk("csr_rdata", csr_rdata, m_read(csr_addr));
    chk("busy", {31'b0, busy}, {31'b0, !idle});
    chk("redirect_valid", {31'b0, redirect_valid}, {31'b0, m_left == 1});
    chk("flush", {31'b0, flush}, {31'b0, m_left == 1});
    if (m_left == 1) chk("redirect_pc", redirect_pc, m_target);
  endtask

  task automatic model_update();
    logic [31:0] old, nv;
    if (rst) begin
      m_mtvec = 0; m_mepc = 0; m_mcause = 0; m_left = 0; m_target = 0;
    end else if (m_left > 0) begin
      if (m_left == 2) begin
        m_mepc   = {m_pc[31:2], 2'b00};
        m_mcause = {28'b0, m_cause};
        m_target = m_mtvec;
      end
      m_left--;
    end else if (trap_valid) begin
      m_pc = trap_pc; m_cause = trap_cause; m_left = 2;
    end else if (mret_valid) begin
      m_target = m_mepc; m_left = 1;
    end else if (csr_valid && csr_op != 2'b00 && m_legal(csr_addr)) begin
      old = m_read(csr_addr);
      if (csr_op == 2'b01)      nv = csr_wdata;
      else if (csr_op == 2'b10) nv = old | csr_wdata;
      else                      nv = old & ~csr_wdata;
      if (csr_addr == 12'h305) m_mtvec  = nv & 32'hFFFF_FFFC;
      if (csr_addr == 12'h341) m_mepc   = nv & 32'hFFFF_FFFC;
      if (csr_addr == 12'h342) m_mcause = nv;
    end
  endtask

  // Called just after a falling edge with inputs already set.
  task automatic step();
    #1;
    model_check();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle_in();
    rst = 0; trap_valid = 0; mret_valid = 0; csr_valid = 0;
    csr_op = 0; csr_addr = 12'h305; csr_wdata = 0;
  endtask

  task automatic csr_acc(input logic [1:0] op, input logic [11:0] a, input logic [31:0] wd,
                         input string tag, input logic [31:0] exp_old);
    csr_valid = 1; csr_op = op; csr_addr = a; csr_wdata = wd;
    #1 chk(tag, csr_rdata, exp_old);
    step();
    csr_valid = 0;
  endtask

  initial begin
    m_mtvec = 0; m_mepc = 0; m_mcause = 0; m_left = 0; m_pc = 0; m_target = 0; m_cause = 0;
    idle_in();
    trap_cause = 0; trap_pc = 0;
    rst = 1;
    @(negedge clk);
    step(); step();
    rst = 0;
    #1 chk("reset_redirect_pc", redirect_pc, 32'h0);

    // MTVEC write masks low bits
    csr_acc(2'b01, CSR_MTVEC, 32'h0000_0103, "mtvec_rw_old", 32'h0);
    csr_acc(2'b00, CSR_MTVEC, 32'h0, "mtvec_read", 32'h0000_0100);

    // ECALL trap
    trap_valid = 1; trap_cause = 4'd11; trap_pc = 32'h0000_2006;
    #1 chk("trap_ready_n", {31'b0, trap_ready}, 32'h1);
    step();
    trap_valid = 0;
    step();
    #1 chk("trap_redir_pc", redirect_pc, 32'h100);
    chk("trap_flush", {31'b0, flush}, 32'h1);
    step();
    csr_acc(2'b00, CSR_MEPC, 32'h0, "mepc_after_trap", 32'h2004);
    csr_acc(2'b00, CSR_MCAUSE, 32'h0, "mcause_after_trap", 32'd11);

    // MRET
    mret_valid = 1;
    step();
    mret_valid = 0;
    #1 chk("mret_redir_pc", redirect_pc, 32'h2004);
    step();
    #1 chk("mret_busy_low", {31'b0, busy}, 32'h0);

    // RS / RC on MCAUSE
    csr_acc(2'b01, CSR_MCAUSE, 32'hF0, "mcause_rw", 32'd11);
    csr_acc(2'b10, CSR_MCAUSE, 32'h0F, "mcause_rs_old", 32'hF0);
    csr_acc(2'b11, CSR_MCAUSE, 32'h30, "mcause_rc_old", 32'hFF);
    csr_acc(2'b00, CSR_MCAUSE, 32'h0, "mcause_final", 32'hCF);

    // Illegal address
    csr_valid = 1; csr_op = 2'b01; csr_addr = 12'h300; csr_wdata = 32'hFFFF_FFFF;
    #1 chk("illegal_flag", {31'b0, csr_illegal}, 32'h1);
    chk("illegal_rdata", csr_rdata, 32'h0);
    step();
    csr_valid = 0;
    csr_acc(2'b00, CSR_MTVEC, 32'h0, "illegal_no_write", 32'h100);

    // Trap + CSR + MRET in the same cycle
    trap_valid = 1; trap_cause = 4'd2; trap_pc = 32'h0000_3001;
    mret_valid = 1;
    csr_valid = 1; csr_op = 2'b01; csr_addr = CSR_MTVEC; csr_wdata = 32'h200;
    #1 chk("sim_csr_ready", {31'b0, csr_ready}, 32'h0);
    chk("sim_mret_ready", {31'b0, mret_ready}, 32'h0);
    step();
    trap_valid = 0;
    step();
    #1 chk("sim_trap_target", redirect_pc, 32'h100);
    step();
    #1 chk("sim_mret_accept", {31'b0, mret_ready}, 32'h1);
    step();
    mret_valid = 0;
    #1 chk("sim_mret_target", redirect_pc, 32'h3000);
    step();
    step();
    csr_valid = 0;
    csr_acc(2'b00, CSR_MTVEC, 32'h0, "sim_csr_late", 32'h200);

    // Reset during SAVE
    trap_valid = 1; trap_cause = 4'd11; trap_pc = 32'h0000_4444;
    step();
    trap_valid = 0; rst = 1;
    step();
    rst = 0;
    #1 chk("abort_no_redirect", {31'b0, redirect_valid}, 32'h0);
    step();
    csr_acc(2'b00, CSR_MTVEC, 32'h0, "abort_mtvec", 32'h0);
    csr_acc(2'b00, CSR_MEPC, 32'h0, "abort_mepc", 32'h0);
    csr_acc(2'b00, CSR_MCAUSE, 32'h0, "abort_mcause", 32'h0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      rst        = ($urandom_range(0, 79) == 0);
      trap_valid = ($urandom_range(0, 5) == 0);
      trap_cause = 4'($urandom);
      trap_pc    = $urandom;
      mret_valid = ($urandom_range(0, 5) == 0);
      csr_valid  = ($urandom_range(0, 1) == 1);
      csr_op     = 2'($urandom);
      case ($urandom_range(0, 3))
        0: csr_addr = CSR_MTVEC;
        1: csr_addr = CSR_MEPC;
        2: csr_addr = CSR_MCAUSE;
        default: csr_addr = 12'($urandom);
      endcase
      csr_wdata = $urandom;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
